// File: rtl/alu_issue_ctl.sv
// Round-robin issue sequencer for the shared 64-bit ALU: two requesters, registered operands,
// status register ownership and a valid/ready response. Define ALU_MUL_MULTICYCLE_EN for multicycle MUL.
module alu_issue_ctl #(
   parameter int MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [63:0] req0_srca,
   input  logic [63:0] req0_srcb,
   input  logic [3:0]  req0_tag,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [63:0] req1_srca,
   input  logic [63:0] req1_srcb,
   input  logic [3:0]  req1_tag,
   output logic [3:0]  alu_op,
   output logic [63:0] alu_srca,
   output logic [63:0] alu_srcb,
   output logic [3:0]  alu_sri,
   input  logic [63:0] alu_dst,
   input  logic [3:0]  alu_sro,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_port,
   output logic [3:0]  rsp_tag,
   output logic [63:0] rsp_dst,
   input  logic        sr_ld,
   input  logic [3:0]  sr_ld_data,
   output logic [3:0]  sr_out,
   output logic        busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] OP_MUL = 4'h3;
`ifdef ALU_MUL_MULTICYCLE_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic [1:0]  r_state;
   logic        r_prio;
   logic [3:0]  r_op, r_tag, r_cnt, r_sr;
   logic [63:0] r_srca, r_srcb, r_dst;
   logic        r_port;

   logic        w_idle, w_gnt0, w_gnt1, w_fire, w_last;
   logic [3:0]  w_op, w_tag, w_len;
   logic [63:0] w_srca, w_srcb;

   // Tie goes to the requester named by r_prio; readies never look at rsp_ready.
   assign w_idle = (r_state == S_IDLE);
   assign w_gnt0 = w_idle && req0_valid && (!req1_valid || !r_prio);
   assign w_gnt1 = w_idle && req1_valid && (!req0_valid || r_prio);
   assign w_fire = w_gnt0 || w_gnt1;
   assign w_last = (r_state == S_EXEC) && (r_cnt == 4'd1);

   always_comb begin
      w_op   = w_gnt1 ? req1_op   : req0_op;
      w_tag  = w_gnt1 ? req1_tag  : req0_tag;
      w_srca = w_gnt1 ? req1_srca : req0_srca;
      w_srcb = w_gnt1 ? req1_srcb : req0_srcb;
      w_len  = (MUL_EN && w_op == OP_MUL) ? 4'(MUL_LAT) : 4'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_prio  <= 1'b0;
         r_op    <= '0;
         r_tag   <= '0;
         r_cnt   <= '0;
         r_srca  <= '0;
         r_srcb  <= '0;
         r_dst   <= '0;
         r_port  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_fire) begin
               r_op    <= w_op;
               r_tag   <= w_tag;
               r_srca  <= w_srca;
               r_srcb  <= w_srcb;
               r_port  <= w_gnt1;
               r_prio  <= ~w_gnt1;
               r_cnt   <= w_len;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_last) begin
                  r_dst   <= alu_dst;
                  r_state <= S_RESP;
               end
               r_cnt <= r_cnt - 4'd1;
            end
            S_RESP: if (rsp_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ALU status update outranks a software load landing in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      r_sr <= '0;
      else if (w_last) r_sr <= alu_sro;
      else if (sr_ld)  r_sr <= sr_ld_data;
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign alu_op     = r_op;
   assign alu_srca   = r_srca;
   assign alu_srcb   = r_srcb;
   assign alu_sri    = r_sr;
   assign sr_out     = r_sr;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_port   = r_port;
   assign rsp_tag    = r_tag;
   assign rsp_dst    = r_dst;
   assign busy       = !w_idle;
endmodule

// File: tb/tb_alu_issue_ctl.sv
// Directed bench for alu_issue_ctl with a small behavioural ALU attached to the alu_* ports.
module tb_alu_issue_ctl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 0, req1_valid = 0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op = 0, req1_op = 0, req0_tag = 0, req1_tag = 0;
   logic [63:0] req0_srca = 0, req0_srcb = 0, req1_srca = 0, req1_srcb = 0;
   logic [3:0]  alu_op, alu_sri, alu_sro;
   logic [63:0] alu_srca, alu_srcb, alu_dst;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_port, busy;
   logic [3:0]  rsp_tag, sr_out;
   logic [63:0] rsp_dst;
   logic        sr_ld = 0;
   logic [3:0]  sr_ld_data = 0;
   int total = 0, bad = 0;

`ifdef ALU_MUL_MULTICYCLE_EN
   localparam int MUL_L = 4;
`else
   localparam int MUL_L = 1;
`endif

   always #5 clk = ~clk;

   alu_issue_ctl #(.MUL_LAT(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_tag(req1_tag),
      .alu_op(alu_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_sri(alu_sri),
      .alu_dst(alu_dst), .alu_sro(alu_sro),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
      .rsp_tag(rsp_tag), .rsp_dst(rsp_dst),
      .sr_ld(sr_ld), .sr_ld_data(sr_ld_data), .sr_out(sr_out), .busy(busy)
   );

   // ALU stand-in: 1 ADD, 2 ADDC (carry-in sri[0]), 3 MUL, 4 XOR; sro[3] flags a real op.
   always_comb begin
      alu_dst = '0;
      alu_sro = alu_sri;
      case (alu_op)
         4'h1: begin alu_dst = alu_srca + alu_srcb;                     alu_sro = 4'h8; end
         4'h2: begin alu_dst = alu_srca + alu_srcb + {63'd0, alu_sri[0]}; alu_sro = 4'h8; end
         4'h3: begin alu_dst = alu_srca * alu_srcb;                     alu_sro = 4'h8; end
         4'h4: begin alu_dst = alu_srca ^ alu_srcb;                     alu_sro = 4'h8; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      // reset state
      nxt(); nxt(); #1;
      chk("rst_rdy0", 64'(req0_ready), 0);
      chk("rst_rdy1", 64'(req1_ready), 0);
      chk("rst_rspv", 64'(rsp_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_sr", 64'(sr_out), 0);
      chk("rst_aop", 64'(alu_op), 0);
      chk("rst_dst", rsp_dst, 0);
      nxt(); reset = 0;

      // single ADD
      nxt();
      req0_valid = 1; req0_op = 4'h1; req0_srca = 5; req0_srcb = 7; req0_tag = 3;
      #1;
      chk("add_rdy0", 64'(req0_ready), 1);
      chk("add_rdy1", 64'(req1_ready), 0);
      nxt(); req0_valid = 0; #1;
      chk("add_exec_busy", 64'(busy), 1);
      chk("add_exec_rspv", 64'(rsp_valid), 0);
      chk("add_exec_srca", alu_srca, 5);
      nxt(); #1;
      chk("add_rspv", 64'(rsp_valid), 1);
      chk("add_dst", rsp_dst, 12);
      chk("add_port", 64'(rsp_port), 0);
      chk("add_tag", 64'(rsp_tag), 3);
      chk("add_sr", 64'(sr_out), 8);
      nxt(); #1;
      chk("add_idle_busy", 64'(busy), 0);
      chk("add_idle_rspv", 64'(rsp_valid), 0);

      // round-robin from fresh reset
      reset = 1; nxt(); reset = 0;
      req0_valid = 1; req0_op = 4'h1; req0_srca = 1; req0_srcb = 1; req0_tag = 4'hA;
      req1_valid = 1; req1_op = 4'h1; req1_srca = 2; req1_srcb = 2; req1_tag = 4'hB;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_rdy0", 64'(req0_ready), (i % 2 == 0) ? 1 : 0);
         chk("rr_rdy1", 64'(req1_ready), (i % 2 == 1) ? 1 : 0);
         nxt(); #1;
         chk("rr_exec_rdy", 64'({req0_ready, req1_ready}), 0);
         nxt(); #1;
         chk("rr_port", 64'(rsp_port), i % 2);
         chk("rr_tag", 64'(rsp_tag), (i % 2 == 1) ? 4'hB : 4'hA);
         chk("rr_dst", rsp_dst, (i % 2 == 1) ? 4 : 2);
         chk("rr_resp_rdy", 64'({req0_ready, req1_ready}), 0);
         nxt(); #1;
      end
      req0_valid = 0; req1_valid = 0;

      // backpressure with XOR, then NONE from req1
      nxt();
      rsp_ready = 0;
      req0_valid = 1; req0_op = 4'h4; req0_srca = 64'hF0; req0_srcb = 64'hFF; req0_tag = 5;
      #1;
      chk("bp_rdy0", 64'(req0_ready), 1);
      nxt();
      req0_valid = 0;
      req1_valid = 1; req1_op = 4'h0; req1_srca = 64'h1234; req1_srcb = 64'h99; req1_tag = 6;
      #1;
      chk("bp_exec_rdy1", 64'(req1_ready), 0);
      for (int k = 0; k < 5; k++) begin
         nxt(); #1;
         chk("bp_rspv", 64'(rsp_valid), 1);
         chk("bp_dst", rsp_dst, 64'h0F);
         chk("bp_busy", 64'(busy), 1);
         chk("bp_rdy1", 64'(req1_ready), 0);
      end
      nxt(); rsp_ready = 1; #1;
      chk("bp_rel_rdy1", 64'(req1_ready), 0);
      nxt(); #1;
      chk("bp_idle_busy", 64'(busy), 0);
      chk("bp_idle_rdy1", 64'(req1_ready), 1);
      nxt(); req1_valid = 0; #1;
      nxt(); #1;
      chk("none_dst", rsp_dst, 0);
      chk("none_port", 64'(rsp_port), 1);
      chk("none_tag", 64'(rsp_tag), 6);
      chk("none_sr", 64'(sr_out), 8);
      nxt();

      // SR load, ADDC uses sri, load in last EXEC cycle dropped
      sr_ld = 1; sr_ld_data = 4'h1;
      nxt(); sr_ld = 0;
      req0_valid = 1; req0_op = 4'h2; req0_srca = 64'hFFFF_FFFF; req0_srcb = 0; req0_tag = 1;
      #1;
      chk("sr_ld", 64'(sr_out), 1);
      chk("sr_rdy0", 64'(req0_ready), 1);
      nxt(); req0_valid = 0; sr_ld = 1; sr_ld_data = 4'h5; #1;
      chk("sr_sri", 64'(alu_sri), 1);
      nxt(); sr_ld = 0; #1;
      chk("addc_dst", rsp_dst, 64'h1_0000_0000);
      chk("sr_drop", 64'(sr_out), 8);
      nxt();

      // MUL
      req0_valid = 1; req0_op = 4'h3; req0_srca = 6; req0_srcb = 7; req0_tag = 2;
      #1;
      chk("mul_rdy0", 64'(req0_ready), 1);
      nxt(); req0_valid = 0;
      for (int k = 0; k < MUL_L; k++) begin
         #1;
         chk("mul_aop", 64'(alu_op), 3);
         chk("mul_srcs", {alu_srca[31:0], alu_srcb[31:0]}, {32'd6, 32'd7});
         chk("mul_rspv_lo", 64'(rsp_valid), 0);
         nxt();
      end
      #1;
      chk("mul_rspv", 64'(rsp_valid), 1);
      chk("mul_dst", rsp_dst, 42);
      nxt();

      // reset mid-EXEC
      req0_valid = 1; req0_op = 4'h3; req0_srca = 6; req0_srcb = 7; req0_tag = 2;
      nxt(); req0_valid = 0; #1;
      chk("mr_busy", 64'(busy), 1);
      reset = 1; #1;
      chk("mr_rst_busy", 64'(busy), 0);
      chk("mr_rst_sr", 64'(sr_out), 0);
      chk("mr_rst_aop", 64'(alu_op), 0);
      nxt(); reset = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("mr_no_rsp", 64'(rsp_valid), 0);
         nxt();
      end
      req1_valid = 1; req1_op = 4'h1; req1_srca = 1; req1_srcb = 2; req1_tag = 9;
      #1;
      chk("mr_rdy1", 64'(req1_ready), 1);
      nxt(); req1_valid = 0;
      nxt(); #1;
      chk("mr_rspv", 64'(rsp_valid), 1);
      chk("mr_dst", rsp_dst, 3);
      chk("mr_port", 64'(rsp_port), 1);
      chk("mr_tag", 64'(rsp_tag), 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
